// File: rtl/alu_result_display.sv
// ALU result display stage: sequential double-dabble conversion of an 8-bit result
// into sign + 3 BCD digits, shown on a 4-digit multiplexed common-anode 7-segment display.
module alu_result_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] value,
    input  logic       signed_mode,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       busy
);

    localparam logic [6:0]       SEG_BLANK = 7'h7F;
    localparam logic [6:0]       SEG_MINUS = 7'h3F;
    localparam logic [CNT_W-1:0] REF_LAST  = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_start;

    logic [8:0]       r_last_pair;
    logic [8:0]       r_conv_pair;
    logic             r_force;
    logic             r_conv_neg;
    logic             r_busy;
    logic [7:0]       r_mag;
    logic [11:0]      r_bcd;
    logic [2:0]       r_bit_cnt;

    logic [3:0]       r_hund;
    logic [3:0]       r_tens;
    logic [3:0]       r_ones;
    logic             r_neg;

    logic [CNT_W-1:0] r_ref_cnt;
    logic [1:0]       r_idx;
    logic [6:0]       r_seg;
    logic [3:0]       r_an;

    logic [8:0]       w_pair;
    logic             w_in_neg;
    logic [7:0]       w_in_mag;
    logic [11:0]      w_bcd_adj;
    logic             w_wrap;
    logic [6:0]       w_seg_nxt;
    logic [3:0]       w_an_nxt;

    function automatic logic [6:0] f_seg7(input logic [3:0] d);
        case (d)
            4'd0:    f_seg7 = 7'h40;
            4'd1:    f_seg7 = 7'h79;
            4'd2:    f_seg7 = 7'h24;
            4'd3:    f_seg7 = 7'h30;
            4'd4:    f_seg7 = 7'h19;
            4'd5:    f_seg7 = 7'h12;
            4'd6:    f_seg7 = 7'h02;
            4'd7:    f_seg7 = 7'h78;
            4'd8:    f_seg7 = 7'h00;
            4'd9:    f_seg7 = 7'h10;
            default: f_seg7 = SEG_BLANK;
        endcase
    endfunction

    assign w_pair   = {signed_mode, value};
    assign w_in_neg = signed_mode & value[7];
    assign w_in_mag = w_in_neg ? (~value + 8'd1) : value;

    // Converter FSM: the pair compare is only evaluated in IDLE, so inputs are ignored while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((w_pair != r_last_pair) || r_force) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: if (r_bit_cnt == 3'd7) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 3; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_pair <= '0;
            r_conv_pair <= '0;
            r_force     <= 1'b1;
            r_conv_neg  <= 1'b0;
            r_busy      <= 1'b0;
            r_mag       <= '0;
            r_bcd       <= '0;
            r_bit_cnt   <= '0;
            r_hund      <= '0;
            r_tens      <= '0;
            r_ones      <= '0;
            r_neg       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_mag       <= w_in_mag;
                        r_bcd       <= '0;
                        r_bit_cnt   <= '0;
                        r_conv_neg  <= w_in_neg;
                        r_conv_pair <= w_pair;
                        r_force     <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    r_bcd     <= {w_bcd_adj[10:0], r_mag[7]};
                    r_mag     <= {r_mag[6:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                S_LOAD: begin
                    r_hund      <= r_bcd[11:8];
                    r_tens      <= r_bcd[7:4];
                    r_ones      <= r_bcd[3:0];
                    r_neg       <= r_conv_neg;
                    r_last_pair <= r_conv_pair;
                    r_busy      <= 1'b0;
                end
                default: r_busy <= 1'b0;
            endcase
        end
    end

    assign w_wrap = (r_ref_cnt == REF_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ref_cnt <= '0;
            r_idx     <= '0;
        end else begin
            r_ref_cnt <= w_wrap ? '0 : r_ref_cnt + 1'b1;
            if (w_wrap) r_idx <= r_idx + 2'd1;
        end
    end

    // Leading-zero blanking: tens only blanks when hundreds is also zero.
    always_comb begin
        w_seg_nxt = SEG_BLANK;
        case (r_idx)
            2'd0: w_seg_nxt = f_seg7(r_ones);
            2'd1: w_seg_nxt = (r_hund == 4'd0 && r_tens == 4'd0) ? SEG_BLANK : f_seg7(r_tens);
            2'd2: w_seg_nxt = (r_hund == 4'd0) ? SEG_BLANK : f_seg7(r_hund);
            default: w_seg_nxt = r_neg ? SEG_MINUS : SEG_BLANK;
        endcase
    end

    assign w_an_nxt = ~(4'b0001 << r_idx);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg <= SEG_BLANK;
            r_an  <= 4'hF;
        end else begin
            r_seg <= w_seg_nxt;
            r_an  <= w_an_nxt;
        end
    end

    assign seg  = r_seg;
    assign an   = r_an;
    assign dp   = 1'b1;
    assign busy = r_busy;

endmodule

// File: tb/tb_alu_result_display.sv
// Bench for alu_result_display: directed scenarios with literal digit checks plus
// randomized stimulus compared every cycle against a cycle-count/arithmetic display model.
module tb_alu_result_display;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] value = 8'd0;
    logic       signed_mode = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    alu_result_display #(.REFRESH_DIV(4), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .value(value), .signed_mode(signed_mode),
        .seg(seg), .an(an), .dp(dp), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic logic [6:0] digit_seg(input int idx, input int val, input logic neg);
        int h, t, o;
        h = val / 100;
        t = (val / 10) % 10;
        o = val % 10;
        case (idx)
            0:       return seg_tbl[o];
            1:       return (h == 0 && t == 0) ? 7'h7F : seg_tbl[t];
            2:       return (h == 0) ? 7'h7F : seg_tbl[h];
            default: return neg ? 7'h3F : 7'h7F;
        endcase
    endfunction

    logic [3:0] m_an;
    logic [6:0] m_seg;
    int         m_busy_left;
    logic       m_force;
    logic [8:0] m_last, m_pend;
    int         m_val;
    logic       m_neg;
    int         m_ref, m_idx;

    // A conversion occupies 9 busy cycles; the displayed number changes when the count runs out.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_an <= 4'hF; m_seg <= 7'h7F; m_busy_left <= 0; m_force <= 1'b1;
            m_last <= '0; m_pend <= '0; m_val <= 0; m_neg <= 1'b0; m_ref <= 0; m_idx <= 0;
        end else begin
            m_an  <= 4'(~(4'b0001 << m_idx));
            m_seg <= digit_seg(m_idx, m_val, m_neg);
            m_ref <= (m_ref + 1) % 4;
            if (m_ref == 3) m_idx <= (m_idx + 1) % 4;
            if (m_busy_left == 0) begin
                if ({signed_mode, value} != m_last || m_force) begin
                    m_busy_left <= 9;
                    m_pend      <= {signed_mode, value};
                    m_force     <= 1'b0;
                end
            end else begin
                m_busy_left <= m_busy_left - 1;
                if (m_busy_left == 1) begin
                    m_neg  <= m_pend[8] & m_pend[7];
                    m_val  <= (m_pend[8] & m_pend[7]) ? 256 - int'(m_pend[7:0]) : int'(m_pend[7:0]);
                    m_last <= m_pend;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("an", 32'(an), 32'(m_an));
            chk("seg", 32'(seg), 32'(m_seg));
            chk("busy", 32'(busy), 32'(m_busy_left != 0));
            chk("dp", 32'(dp), 32'd1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic count_busy(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (busy === 1'b1) cnt++;
        end
    endtask

    task automatic capture(output logic [6:0] d0, output logic [6:0] d1,
                           output logic [6:0] d2, output logic [6:0] d3);
        d0 = 7'h55; d1 = 7'h55; d2 = 7'h55; d3 = 7'h55;
        repeat (16) begin
            @(negedge clk);
            case (an)
                4'hE: d0 = seg;
                4'hD: d1 = seg;
                4'hB: d2 = seg;
                4'h7: d3 = seg;
                default: ;
            endcase
        end
    endtask

    task automatic check_digits(input string name, input logic [6:0] e3, input logic [6:0] e2,
                                input logic [6:0] e1, input logic [6:0] e0);
        logic [6:0] d0, d1, d2, d3;
        capture(d0, d1, d2, d3);
        chk({name, "_d3"}, 32'(d3), 32'(e3));
        chk({name, "_d2"}, 32'(d2), 32'(e2));
        chk({name, "_d1"}, 32'(d1), 32'(e1));
        chk({name, "_d0"}, 32'(d0), 32'(e0));
    endtask

    function automatic logic [7:0] pick_value();
        case ($urandom_range(0, 7))
            0: return 8'h00;
            1: return 8'h80;
            2: return 8'hFF;
            3: return 8'h7F;
            4: return 8'd99;
            5: return 8'd100;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        logic [3:0] a [64];
        logic [3:0] seq [4];
        int f, pos0;
        seq[0] = 4'hE; seq[1] = 4'hD; seq[2] = 4'hB; seq[3] = 4'h7;

        // 1. reset and forced conversion of 0
        #1 reset = 1'b1;
        chk_en = 1'b1;
        tick(3);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        count_busy(12, bc);
        chk("t1_busy_cycles", 32'(bc), 32'd9);
        check_digits("t1", 7'h7F, 7'h7F, 7'h7F, 7'h40);

        // 2. unsigned 255
        tick(1);
        value = 8'd255; signed_mode = 1'b0;
        count_busy(12, bc);
        chk("t2_busy_cycles", 32'(bc), 32'd9);
        chk("t2_model_val", 32'(m_val), 32'd255);
        check_digits("t2", 7'h7F, 7'h24, 7'h12, 7'h12);

        // 3. signed -128, then -1
        tick(1);
        value = 8'h80; signed_mode = 1'b1;
        tick(12);
        chk("t3_model_val", 32'(m_val), 32'd128);
        chk("t3_model_neg", 32'(m_neg), 32'd1);
        check_digits("t3a", 7'h3F, 7'h79, 7'h24, 7'h00);
        tick(1);
        value = 8'hFF;
        tick(12);
        check_digits("t3b", 7'h3F, 7'h7F, 7'h7F, 7'h79);

        // 4. 7 then 42 mid-conversion
        tick(1);
        value = 8'd7;
        count_busy(3, bc);
        begin
            int bc2;
            tick(1);
            value = 8'd42;
            count_busy(17, bc2);
            chk("t4_busy_cycles", 32'(bc + bc2), 32'd18);
        end
        tick(1);
        check_digits("t4", 7'h7F, 7'h7F, 7'h19, 7'h24);

        // 5. reset during SHIFT of 99
        tick(1);
        value = 8'd99; signed_mode = 1'b0;
        tick(3);
        reset = 1'b1;
        #1;
        chk("t5_rst_an", 32'(an), 32'hF);
        chk("t5_rst_seg", 32'(seg), 32'h7F);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        tick(2);
        reset = 1'b0;
        count_busy(12, bc);
        chk("t5_busy_cycles", 32'(bc), 32'd9);
        check_digits("t5", 7'h7F, 7'h7F, 7'h10, 7'h10);

        // 6. free-run scan pattern
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            a[k] = an;
            chk("t6_onehot", 32'($countones(~a[k])), 32'd1);
        end
        f = 0;
        for (int k = 63; k >= 1; k--) if (a[k] != a[k-1]) f = k;
        chk("t6_found_change", 32'(f != 0), 32'd1);
        if (f != 0) begin
            pos0 = 0;
            for (int p = 0; p < 4; p++) if (seq[p] == a[f]) pos0 = p;
            for (int k = f; k < 64; k++)
                chk("t6_an_seq", 32'(a[k]), 32'(seq[(pos0 + (k - f) / 4) % 4]));
        end

        // randomized phase against the model
        tick(1);
        for (int it = 0; it < 1500; it++) begin
            int r;
            tick(1);
            r = int'($urandom_range(0, 99));
            if (r < 15) value = pick_value();
            else if (r < 18) signed_mode = ~signed_mode;
            else if (r == 18 && $urandom_range(0, 9) == 0) begin
                reset = 1'b1;
                tick(int'($urandom_range(1, 2)));
                reset = 1'b0;
            end
        end
        tick(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
